spi_slave_gen: RTL and testbench

SPI_SLAVE_GEN -- requirements
Module: spi_slave_gen

---
 rtl/spi_slave_gen_if.sv | 25 ++
 rtl/spi_slave_gen.sv | 161 ++++++++++++++++
 tb/tb_spi_slave_gen.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_gen_if.sv
// SPI slave bus: serial pins (ss_n/mosi/miso) plus the parallel rx/tx side.
interface spi_slave_gen_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int RX_W = DATA_WIDTH + 2;

  logic                  ss_n;
  logic                  mosi;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  miso;
  logic [RX_W-1:0]       rx_data;
  logic                  rx_valid;
  logic                  frame_err;

  modport slave (
    input  ss_n, mosi, tx_data, tx_valid,
    output miso, rx_data, rx_valid, frame_err
  );

  modport master (
    output ss_n, mosi, tx_data, tx_valid,
    input  miso, rx_data, rx_valid, frame_err
  );
endinterface

// File: rtl/spi_slave_gen.sv
// SPI slave: 2-bit command + payload frames on ss_n/mosi, read-data payload returned on miso.
// Define SPI_FRAME_ERR_EN to build the aborted-frame detector driving frame_err.
module spi_slave_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int MSB_FIRST  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_slave_gen_if.slave bus_if,
  output logic [2:0]     state_o
);
  localparam int RX_W  = DATA_WIDTH + 2;
  localparam int CNT_W = $clog2(RX_W + 1);
  localparam int IDX_W = $clog2(RX_W);

  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ, TX_WAIT, TX_SHIFT, DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [RX_W-1:0]       rx_sh_q, rx_sh_d;
  logic [RX_W-1:0]       rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic                  miso_q, miso_d;

  logic [IDX_W-1:0]      bit_pos;
  logic [RX_W-1:0]       rx_shifted;
  logic                  cmd_lsb;
  logic                  tx_first_bit, tx_next_bit;
  logic [DATA_WIDTH-1:0] tx_load_rest, tx_sh_adv;

  // Bit order only changes where a bit lands / which tx bit goes next.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign bit_pos      = IDX_W'(RX_W - 1) - IDX_W'(cnt_q);
      assign cmd_lsb      = rx_shifted[RX_W-2];
      assign tx_first_bit = bus_if.tx_data[DATA_WIDTH-1];
      assign tx_load_rest = {bus_if.tx_data[DATA_WIDTH-2:0], 1'b0};
      assign tx_next_bit  = tx_sh_q[DATA_WIDTH-1];
      assign tx_sh_adv    = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign bit_pos      = IDX_W'(cnt_q);
      assign cmd_lsb      = rx_shifted[1];
      assign tx_first_bit = bus_if.tx_data[0];
      assign tx_load_rest = {1'b0, bus_if.tx_data[DATA_WIDTH-1:1]};
      assign tx_next_bit  = tx_sh_q[0];
      assign tx_sh_adv    = {1'b0, tx_sh_q[DATA_WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    rx_shifted          = rx_sh_q;
    rx_shifted[bit_pos] = bus_if.mosi;
  end

  // tx handshake: tx_valid has no ready; it is accepted only in TX_WAIT, on the
  // cycle it is high, and tx_data is captured on that same edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_sh_d    = tx_sh_q;
    miso_d     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!bus_if.ss_n) state_d = CHK_CMD;
      end
      CHK_CMD: begin
        rx_sh_d = rx_shifted;
        cnt_d   = CNT_W'(1);
        state_d = bus_if.mosi ? READ : WRITE;
      end
      WRITE, READ: begin
        rx_sh_d = rx_shifted;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(RX_W - 1)) begin
          rx_data_d  = rx_shifted;
          rx_valid_d = 1'b1;
          cnt_d      = '0;
          state_d    = (state_q == READ && cmd_lsb) ? TX_WAIT : DONE;
        end
      end
      TX_WAIT: begin
        if (bus_if.tx_valid) begin
          tx_sh_d = tx_load_rest;
          miso_d  = tx_first_bit;
          cnt_d   = CNT_W'(1);
          state_d = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (cnt_q == CNT_W'(DATA_WIDTH)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          miso_d  = tx_next_bit;
          tx_sh_d = tx_sh_adv;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    // Deselect wins over frame completion and tx_valid in the same cycle.
    if (bus_if.ss_n) begin
      state_d    = IDLE;
      cnt_d      = '0;
      miso_d     = 1'b0;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_sh_q    <= '0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_sh_q    <= tx_sh_d;
      miso_q     <= miso_d;
    end
  end

`ifdef SPI_FRAME_ERR_EN
  logic frame_err_q, frame_err_d;

  always_comb begin
    frame_err_d = bus_if.ss_n &&
                  (state_q inside {CHK_CMD, WRITE, READ, TX_WAIT, TX_SHIFT});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_err_d;
  end

  assign bus_if.frame_err = frame_err_q;
`else
  assign bus_if.frame_err = 1'b0;
`endif

  assign bus_if.miso     = miso_q;
  assign bus_if.rx_data  = rx_data_q;
  assign bus_if.rx_valid = rx_valid_q;
  assign state_o         = state_q;
endmodule

// File: tb/tb_spi_slave_gen.sv
// Bench for spi_slave_gen: an 8-bit MSB-first instance and a 16-bit LSB-first instance,
// random frames checked against a bit-stream model of frame placement and tx order.
`timescale 1ns/1ps
module tb_spi_slave_gen;
  localparam int DW_A = 8;
  localparam int RX_A = DW_A + 2;
  localparam int DW_B = 16;
  localparam int RX_B = DW_B + 2;
`ifdef SPI_FRAME_ERR_EN
  localparam int FE_EN = 1;
`else
  localparam int FE_EN = 0;
`endif

  typedef bit bitq_t[$];

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_gen_if #(.DATA_WIDTH(DW_A)) a_if ();
  spi_slave_gen_if #(.DATA_WIDTH(DW_B)) b_if ();
  logic [2:0] a_state, b_state;

  spi_slave_gen #(.DATA_WIDTH(DW_A), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus_if(a_if), .state_o(a_state)
  );
  spi_slave_gen #(.DATA_WIDTH(DW_B), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus_if(b_if), .state_o(b_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int fe_exp_a = 0;
  int fe_seen_a = 0;
  int fe_seen_b = 0;
  bit mon_en = 1'b0;
  logic [RX_A-1:0] last_rx_a = '0;
  logic [RX_A-1:0] exp_qa[$];
  logic [RX_B-1:0] exp_qb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // reference model: frames as bit streams in wire order
  function automatic bitq_t mk_a(input logic [1:0] cmd, input logic [DW_A-1:0] p);
    bitq_t q;
    q.push_back(cmd[1]);
    q.push_back(cmd[0]);
    for (int i = DW_A - 1; i >= 0; i--) q.push_back(p[i]);
    return q;
  endfunction

  function automatic logic [RX_A-1:0] place_a(input bitq_t s);
    logic [RX_A-1:0] r = '0;
    for (int i = 0; i < RX_A; i++) r[RX_A-1-i] = s[i];
    return r;
  endfunction

  function automatic logic [RX_B-1:0] place_b(input bitq_t s);
    logic [RX_B-1:0] r = '0;
    for (int i = 0; i < RX_B; i++) r[i] = s[i];
    return r;
  endfunction

  // scoreboard monitors
  always @(negedge clk) begin
    if (mon_en) begin
      if (a_if.rx_valid) begin
        if (exp_qa.size() > 0) check("a_rx_data", 32'(a_if.rx_data), 32'(exp_qa.pop_front()));
        else check("a_rx_valid_spurious", 32'(a_if.rx_valid), 32'(0));
      end
      if (b_if.rx_valid) begin
        if (exp_qb.size() > 0) check("b_rx_data", 32'(b_if.rx_data), 32'(exp_qb.pop_front()));
        else check("b_rx_valid_spurious", 32'(b_if.rx_valid), 32'(0));
      end
      if (a_if.frame_err) fe_seen_a++;
      if (b_if.frame_err) fe_seen_b++;
    end
  end

  // driver for instance A; n_sent < RX_A aborts the receive phase,
  // tx_abort >= 0 aborts after that many tx bits (0 = on the tx_valid cycle)
  task automatic frame_a(input bitq_t s, input int n_sent, input int tx_wait, input int tx_abort,
                         input bit rst_in_tx, input logic [RX_A-1:0] exp_rx,
                         input logic [DW_A-1:0] txd);
    @(negedge clk);
    a_if.ss_n = 1'b0; a_if.mosi = 1'($urandom);
    a_if.tx_valid = 1'($urandom); a_if.tx_data = DW_A'($urandom);
    for (int i = 0; i < n_sent; i++) begin
      @(negedge clk);
      check("a_miso_rx", 32'(a_if.miso), 32'(0));
      a_if.mosi = s[i]; a_if.tx_valid = 1'($urandom);
    end
    if (n_sent < RX_A) begin
      @(negedge clk);
      a_if.ss_n = 1'b1; fe_exp_a++;
      @(negedge clk);
      check("a_miso_abort", 32'(a_if.miso), 32'(0));
      check("a_rx_hold", 32'(a_if.rx_data), 32'(last_rx_a));
      return;
    end
    exp_qa.push_back(exp_rx);
    last_rx_a = exp_rx;
    if (s[0] && s[1]) begin
      for (int w = 0; w < tx_wait; w++) begin
        @(negedge clk);
        check("a_miso_wait", 32'(a_if.miso), 32'(0));
        a_if.tx_valid = 1'b0; a_if.mosi = 1'($urandom); a_if.tx_data = DW_A'($urandom);
      end
      @(negedge clk);
      check("a_miso_wait", 32'(a_if.miso), 32'(0));
      a_if.tx_valid = 1'b1; a_if.tx_data = txd;
      if (tx_abort == 0) begin
        a_if.ss_n = 1'b1; fe_exp_a++;
        @(negedge clk);
        a_if.tx_valid = 1'b0;
        check("a_miso_txabort", 32'(a_if.miso), 32'(0));
        return;
      end
      for (int i = 0; i < DW_A; i++) begin
        @(negedge clk);
        check("a_miso_tx", 32'(a_if.miso), 32'(txd[DW_A-1-i]));
        a_if.tx_valid = 1'($urandom); a_if.tx_data = DW_A'($urandom);
        if (tx_abort == i + 1) begin
          if (rst_in_tx) begin
            rst_n = 1'b0; last_rx_a = '0;
          end else begin
            a_if.ss_n = 1'b1; fe_exp_a++;
          end
          @(negedge clk);
          rst_n = 1'b1; a_if.ss_n = 1'b1;
          check("a_miso_txabort", 32'(a_if.miso), 32'(0));
          if (rst_in_tx) check("a_rx_after_rst", 32'(a_if.rx_data), 32'(0));
          return;
        end
      end
      @(negedge clk);
      check("a_miso_tx_end", 32'(a_if.miso), 32'(0));
    end
    repeat (1 + $urandom_range(0, 2)) begin
      @(negedge clk);
      check("a_miso_done", 32'(a_if.miso), 32'(0));
      a_if.mosi = 1'($urandom); a_if.tx_valid = 1'($urandom);
    end
    @(negedge clk);
    a_if.ss_n = 1'b1; a_if.tx_valid = 1'($urandom);
  endtask

  // driver for instance B (LSB-first, full frames)
  task automatic frame_b(input bitq_t s, input logic [RX_B-1:0] exp_rx, input logic [DW_B-1:0] txd);
    @(negedge clk);
    b_if.ss_n = 1'b0; b_if.mosi = 1'($urandom); b_if.tx_valid = 1'b0;
    for (int i = 0; i < RX_B; i++) begin
      @(negedge clk);
      check("b_miso_rx", 32'(b_if.miso), 32'(0));
      b_if.mosi = s[i];
    end
    exp_qb.push_back(exp_rx);
    if (s[0] && s[1]) begin
      @(negedge clk);
      b_if.tx_valid = 1'b1; b_if.tx_data = txd;
      for (int i = 0; i < DW_B; i++) begin
        @(negedge clk);
        check("b_miso_tx", 32'(b_if.miso), 32'(txd[i]));
        b_if.tx_valid = 1'b0; b_if.tx_data = DW_B'($urandom);
      end
      @(negedge clk);
      check("b_miso_tx_end", 32'(b_if.miso), 32'(0));
    end
    @(negedge clk);
    b_if.ss_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bitq_t s;
    int fe0;
    logic [1:0] cmd;
    logic [DW_A-1:0] p;
    a_if.ss_n = 1'b1; a_if.mosi = 1'b0; a_if.tx_valid = 1'b0; a_if.tx_data = '0;
    b_if.ss_n = 1'b1; b_if.mosi = 1'b0; b_if.tx_valid = 1'b0; b_if.tx_data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    check("a_rst_rx_data", 32'(a_if.rx_data), 32'(0));
    check("a_rst_rx_valid", 32'(a_if.rx_valid), 32'(0));
    check("a_rst_miso", 32'(a_if.miso), 32'(0));
    check("a_rst_frame_err", 32'(a_if.frame_err), 32'(0));
    check("b_rst_rx_data", 32'(b_if.rx_data), 32'(0));

    // write-address frame 00_10100101
    frame_a(mk_a(2'b00, 8'hA5), RX_A, 0, -1, 1'b0, 10'h0A5, '0);
    // read-data frame, tx_valid three cycles later with C3
    frame_a(mk_a(2'b11, 8'h00), RX_A, 3, -1, 1'b0, 10'h300, 8'hC3);
    // abort after 5 bits
    fe0 = fe_seen_a;
    frame_a(mk_a(2'b01, 8'h5A), 5, 0, -1, 1'b0, '0, '0);
    @(negedge clk);
    check("a_abort5_ferr", 32'(fe_seen_a - fe0), 32'(FE_EN));
    // abort on the cycle the last bit would be sampled, and in CHK_CMD
    frame_a(mk_a(2'b10, 8'hFF), RX_A - 1, 0, -1, 1'b0, '0, '0);
    frame_a(mk_a(2'b00, 8'h01), 0, 0, -1, 1'b0, '0, '0);
    // deselect together with tx_valid in TX_WAIT
    frame_a(mk_a(2'b11, 8'h3C), RX_A, 1, 0, 1'b0, 10'h33C, 8'hFF);
    // reset during TX_SHIFT, then a clean frame
    fe0 = fe_seen_a;
    frame_a(mk_a(2'b11, 8'h81), RX_A, 2, 4, 1'b1, 10'h381, 8'hA5);
    @(negedge clk);
    check("a_rst_tx_ferr", 32'(fe_seen_a - fe0), 32'(0));
    frame_a(mk_a(2'b01, 8'h96), RX_A, 0, -1, 1'b0, 10'h196, '0);

    for (int k = 0; k < 24; k++) begin
      int n_sent, tx_abort;
      cmd = 2'($urandom); p = DW_A'($urandom);
      s = mk_a(cmd, p);
      n_sent   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, RX_A - 1) : RX_A;
      tx_abort = ($urandom_range(0, 4) == 0) ? $urandom_range(0, DW_A) : -1;
      frame_a(s, n_sent, $urandom_range(0, 4), tx_abort, 1'b0, place_a(s), DW_A'($urandom));
    end

    // LSB-first: first wire bit lands in rx_data[0]
    s = {1'b0, 1'b1, 1'b1};
    repeat (RX_B - 3) s.push_back(1'b0);
    frame_b(s, 18'h00006, '0);
    for (int k = 0; k < 6; k++) begin
      s = {};
      for (int i = 0; i < RX_B; i++) s.push_back(1'($urandom));
      if (k == 0) begin s[0] = 1'b1; s[1] = 1'b1; end
      frame_b(s, place_b(s), DW_B'($urandom));
    end

    repeat (4) @(negedge clk);
    check("a_exp_q_empty", 32'(exp_qa.size()), 32'(0));
    check("b_exp_q_empty", 32'(exp_qb.size()), 32'(0));
    check("a_frame_err_count", 32'(fe_seen_a), 32'(FE_EN * fe_exp_a));
    check("b_frame_err_count", 32'(fe_seen_b), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
